main_mem_responder: RTL and testbench
=====================================

Name: main_mem_responder

Overview:
- Backing data memory that sits behind the write-through cache controller and answers its miss and write-through traffic.
- The cache controller is the initiator. This block is the responder.
- Serves two request types, one outstanding at a time:
  - block-fill read: returns BLOCK_WORDS words as a beat stream;
  - single-word write-through.
- Each request sees a fixed programmable latency. This models slow main memory, so the cache's Stall path is exercised.

Parameters:
- ADDR_W, 10, word-address width (1024 words).
- DATA_W, 32, word width.
- BLOCK_WORDS, 4, words per cache block (power of two, ≥2).
- RD_LATENCY, 4, cycles from read acceptance to first beat (≥1).
- WR_LATENCY, 4, cycles from write acceptance to commit (≥1).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_write  in  1  1 = word write, 0 = block read.
- req_addr  in  ADDR_W  word address. For reads, the low log2(BLOCK_WORDS) bits are ignored.
- req_wdata  in  DATA_W  write data.
- req_ready  out  1  high only in IDLE. A request is accepted on an edge where req_valid & req_ready.
- rd_valid  out  1  read beat valid.
- rd_data  out  DATA_W  read beat data.
- rd_beat  out  log2(BLOCK_WORDS)  beat index within block.
- rd_last  out  1  final beat of block.
- wr_done  out  1  one-cycle pulse: write committed.
- busy  out  1  equals ~req_ready.

Behaviour:
- Reset (async, any state):
  - state = IDLE, counters = 0.
  - rd_valid, rd_last, wr_done, rd_beat, rd_data = 0.
  - req_ready = 1, busy = 0.
  - Array contents are not reset.
  - A write not yet committed is dropped. A burst in progress is truncated with no further beats.
- States: IDLE, WAIT, BURST, DONE.
- IDLE:
  - On acceptance edge E0, latch req_write, req_addr and req_wdata. Later input changes are ignored.
  - Read base address = req_addr with the low log2(BLOCK_WORDS) bits cleared.
  - Load the latency counter with (RD_LATENCY or WR_LATENCY) − 1, then go to WAIT.
- WAIT:
  - Decrement the counter each edge.
  - Read: on the edge where counter == 0, go to BURST.
  - Write: on the edge where counter == 0, go to DONE and write mem[addr] = wdata on that same edge (edge E0+WR_LATENCY).
- DONE (write only): wr_done = 1 for exactly this cycle, then IDLE.
- BURST (read only):
  - One beat per cycle for BLOCK_WORDS consecutive cycles.
  - The first beat is visible in the cycle after edge E0+RD_LATENCY.
  - Beat i: rd_valid = 1, rd_beat = i, rd_data = mem[base+i].
  - rd_last = 1 only on beat BLOCK_WORDS−1, after which the state returns to IDLE.
  - Beats never wrap outside the block. There is no backpressure: the initiator must take every beat.
- Outputs are registered. rd_data is 0 when rd_valid = 0.
- req_ready reasserts in the cycle after the wr_done cycle or the rd_last cycle. Minimum request spacing:
  - write: WR_LATENCY+1 cycles;
  - read: RD_LATENCY+BLOCK_WORDS cycles.
- A req_valid that is held while busy is neither lost nor double-accepted. It is accepted at the first IDLE edge.
- Ordering: a single outstanding request means a read accepted after wr_done always returns the new data.
- Address arithmetic is modulo 2^ADDR_W. Base+i never overflows because the base is block-aligned.

Test Plan:
- Write, then read:
  - Stimulus: reset; write addr 0x005 data 0xDEADBEEF; then block read addr 0x006.
  - Required: wr_done exactly 4 cycles after acceptance.
  - Required: 4 beats with rd_beat 0..3 from words 0x004..0x007; beat 1 = 0xDEADBEEF; rd_last only on beat 3.
- Top-of-memory read:
  - Stimulus: read req_addr 0x3FF.
  - Required: base 0x3FC, beats 0x3FC..0x3FF, no wrap to 0x000.
  - Required: first beat in the cycle after edge E0+RD_LATENCY.
- Held request while busy:
  - Stimulus: hold req_valid high continuously for write A, then read B.
  - Required: B accepted on the first edge after the wr_done cycle; exactly one write and one read performed.
- Reset mid-write:
  - Stimulus: write 0x010 = 0x12345678, assert reset_n = 0 during WAIT, release, then read block 0x010.
  - Required: no wr_done pulse; word 0x010 keeps its old value; all outputs 0 during reset.
- Reset mid-burst:
  - Stimulus: assert reset during beat 1.
  - Required: rd_valid drops asynchronously; no rd_last; req_ready = 1 after release.
- Minimum latency:
  - Stimulus: RD_LATENCY = WR_LATENCY = 1; back-to-back write, then read of the same block.
  - Required: wr_done in the cycle after acceptance; read returns the new data; spacing is exactly 2 and 5 cycles.

Source files
------------

// File: rtl/main_mem_responder_if.sv
`default_nettype none
//==============================================================================
// main_mem_responder_if : request/response bundle between cache and main memory
// Rev 1.0
//==============================================================================
interface main_mem_responder_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int BEAT_W = 2
);
  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic [BEAT_W-1:0] rd_beat;
  logic              rd_last;
  logic              wr_done;
  logic              busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rd_valid, rd_data, rd_beat, rd_last, wr_done, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rd_valid, rd_data, rd_beat, rd_last, wr_done, busy
  );
endinterface
`default_nettype wire

// File: rtl/main_mem_responder.sv
`default_nettype none
//==============================================================================
// main_mem_responder : fixed-latency backing memory for block fills / write-through
// Rev 1.0
//==============================================================================
module main_mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int BLOCK_WORDS = 4,
  parameter int RD_LATENCY  = 4,
  parameter int WR_LATENCY  = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  main_mem_responder_if.slave bus
);

  localparam int BEAT_W  = $clog2(BLOCK_WORDS);
  localparam int LAT_MAX = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
  localparam int DEPTH   = 1 << ADDR_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CNT_W-1:0]  C_RD_LOAD   = CNT_W'(RD_LATENCY - 1);
  localparam logic [CNT_W-1:0]  C_WR_LOAD   = CNT_W'(WR_LATENCY - 1);
  localparam logic [BEAT_W-1:0] C_LAST_BEAT = BEAT_W'(BLOCK_WORDS - 1);

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_req_ready;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;
  logic [BEAT_W-1:0] r_rd_beat;
  logic              r_rd_last;
  logic              r_wr_done;

  logic              w_accept;
  logic              w_wait_end;
  logic              w_mem_we;
  logic [BEAT_W-1:0] w_next_beat;
  logic [BEAT_W-1:0] w_fetch_beat;
  logic [ADDR_W-1:0] w_rd_addr;

  assign w_accept     = bus.req_valid & r_req_ready;
  assign w_wait_end   = (r_state == S_WAIT) && (r_cnt == '0);
  assign w_mem_we     = w_wait_end & r_write;
  assign w_next_beat  = r_rd_beat + 1'b1;
  // Beat index is spliced into the aligned base, so fetches can never leave the block
  assign w_fetch_beat = (r_state == S_BURST) ? w_next_beat : '0;
  assign w_rd_addr    = {r_addr[ADDR_W-1:BEAT_W], w_fetch_beat};

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_req_ready <= 1'b1;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
      r_rd_beat   <= '0;
      r_rd_last   <= 1'b0;
      r_wr_done   <= 1'b0;
    end else begin
      r_wr_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_write     <= bus.req_write;
            r_wdata     <= bus.req_wdata;
            r_addr      <= bus.req_write ? bus.req_addr
                                         : {bus.req_addr[ADDR_W-1:BEAT_W], {BEAT_W{1'b0}}};
            r_cnt       <= bus.req_write ? C_WR_LOAD : C_RD_LOAD;
            r_req_ready <= 1'b0;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            if (r_write) begin
              r_wr_done <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              r_rd_valid <= 1'b1;
              r_rd_beat  <= '0;
              r_rd_data  <= r_mem[w_rd_addr];
              r_rd_last  <= 1'b0;
              r_state    <= S_BURST;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_BURST: begin
          if (r_rd_beat == C_LAST_BEAT) begin
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
            r_rd_beat   <= '0;
            r_rd_last   <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_rd_beat <= w_next_beat;
            r_rd_data <= r_mem[w_rd_addr];
            r_rd_last <= (w_next_beat == C_LAST_BEAT);
          end
        end
        S_DONE: begin
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: begin
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.busy      = ~r_req_ready;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.rd_data   = r_rd_data;
  assign bus.rd_beat   = r_rd_beat;
  assign bus.rd_last   = r_rd_last;
  assign bus.wr_done   = r_wr_done;

endmodule
`default_nettype wire

// File: tb/tb_main_mem_responder.sv
`default_nettype none
//==============================================================================
// tb_main_mem_responder : directed bench for main_mem_responder (latency 4 and 1)
// Rev 1.0
//==============================================================================
module tb_main_mem_responder;

  logic clk;
  logic reset_n;
  int   n_pass  = 0;
  int   n_total = 0;
  int   n_wr_a  = 0;
  int   n_last_a = 0;

  logic [31:0] cap_data [4];
  logic [1:0]  cap_beat [4];
  logic        cap_last [4];
  logic [31:0] capb     [4];

  main_mem_responder_if #(.ADDR_W(10), .DATA_W(32), .BEAT_W(2)) a_bus ();
  main_mem_responder_if #(.ADDR_W(10), .DATA_W(32), .BEAT_W(2)) b_bus ();

  main_mem_responder #(
    .ADDR_W(10), .DATA_W(32), .BLOCK_WORDS(4), .RD_LATENCY(4), .WR_LATENCY(4)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .bus(a_bus)
  );

  main_mem_responder #(
    .ADDR_W(10), .DATA_W(32), .BLOCK_WORDS(4), .RD_LATENCY(1), .WR_LATENCY(1)
  ) u_dut_fast (
    .clk(clk), .reset_n(reset_n), .bus(b_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle
  always @(negedge clk) begin
    if (a_bus.wr_done) n_wr_a++;
    if (a_bus.rd_last) n_last_a++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [38:0] a_outs();
    return {a_bus.req_ready, a_bus.busy, a_bus.rd_valid, a_bus.rd_last,
            a_bus.wr_done, a_bus.rd_beat, a_bus.rd_data};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_issue(input logic wr, input logic [9:0] addr, input logic [31:0] data);
    a_bus.req_valid = 1'b1;
    a_bus.req_write = wr;
    a_bus.req_addr  = addr;
    a_bus.req_wdata = data;
    step();
    a_bus.req_valid = 1'b0;
  endtask

  task automatic a_wait_done(output int cyc);
    cyc = 0;
    while (!a_bus.wr_done && cyc < 20) begin
      step();
      cyc++;
    end
    step();
  endtask

  task automatic a_write(input logic [9:0] addr, input logic [31:0] data);
    int c;
    a_issue(1'b1, addr, data);
    a_wait_done(c);
    check("preload wr latency", 64'(c), 64'd4);
  endtask

  task automatic a_burst(output int first);
    int cyc = 0;
    while (!a_bus.rd_valid && cyc < 20) begin
      step();
      cyc++;
    end
    first = cyc;
    for (int i = 0; i < 4; i++) begin
      cap_data[i] = a_bus.rd_data;
      cap_beat[i] = a_bus.rd_beat;
      cap_last[i] = a_bus.rd_last;
      step();
    end
  endtask

  task automatic check_burst(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] ex [4];
    ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s beat%0d", tag, i), {29'd0, cap_beat[i], cap_last[i], cap_data[i]},
            {29'd0, i[1:0], (i == 3), ex[i]});
    end
  endtask

  task automatic run_b(output int nbusy, output int done_at, output int first_at,
                       output int last_at);
    int cyc = 0;
    nbusy = 0; done_at = -1; first_at = -1; last_at = -1;
    while (b_bus.busy && cyc < 32) begin
      if (b_bus.wr_done && done_at < 0) done_at = cyc;
      if (b_bus.rd_valid) begin
        if (first_at < 0) first_at = cyc;
        capb[b_bus.rd_beat] = b_bus.rd_data;
        if (b_bus.rd_last) last_at = cyc;
      end
      nbusy++;
      cyc++;
      step();
    end
  endtask

  initial begin
    int c, first, w0, l0, nb, da, fa, la;

    a_bus.req_valid = 0; a_bus.req_write = 0; a_bus.req_addr = '0; a_bus.req_wdata = '0;
    b_bus.req_valid = 0; b_bus.req_write = 0; b_bus.req_addr = '0; b_bus.req_wdata = '0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    check("reset outs a", 64'(a_outs()), 64'({1'b1, 38'd0}));
    check("reset ready b", {62'd0, b_bus.req_ready, b_bus.busy}, 64'd2);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Write then block read
    a_write(10'h004, 32'h1111_0004);
    a_write(10'h006, 32'h1111_0006);
    a_write(10'h007, 32'h1111_0007);
    a_issue(1'b1, 10'h005, 32'hDEAD_BEEF);
    a_wait_done(c);
    check("t1 wr_done latency", 64'(c), 64'd4);
    a_issue(1'b0, 10'h006, 32'h0);
    a_burst(first);
    check("t1 first beat latency", 64'(first), 64'd4);
    check_burst("t1", 32'h1111_0004, 32'hDEAD_BEEF, 32'h1111_0006, 32'h1111_0007);
    check("t1 idle after burst", {61'd0, a_bus.req_ready, a_bus.rd_valid, |a_bus.rd_data}, 64'd4);

    // Top-of-memory block, no wrap to word 0
    a_write(10'h3FC, 32'hF00D_03FC);
    a_write(10'h3FD, 32'hF00D_03FD);
    a_write(10'h3FE, 32'hF00D_03FE);
    a_write(10'h3FF, 32'hF00D_03FF);
    a_write(10'h000, 32'h0000_BAD0);
    a_issue(1'b0, 10'h3FF, 32'h0);
    a_burst(first);
    check("t2 first beat latency", 64'(first), 64'd4);
    check_burst("t2", 32'hF00D_03FC, 32'hF00D_03FD, 32'hF00D_03FE, 32'hF00D_03FF);

    // Request held across busy: write A then read B
    a_write(10'h020, 32'h0000_0020);
    a_write(10'h021, 32'h0000_0021);
    a_write(10'h022, 32'h0000_0022);
    a_write(10'h023, 32'h0000_0023);
    w0 = n_wr_a; l0 = n_last_a;
    a_bus.req_valid = 1'b1; a_bus.req_write = 1'b1;
    a_bus.req_addr = 10'h022; a_bus.req_wdata = 32'hCAFE_0022;
    step();
    a_bus.req_write = 1'b0; a_bus.req_addr = 10'h021; a_bus.req_wdata = 32'hFFFF_FFFF;
    c = 0;
    while (!a_bus.wr_done && c < 20) begin
      step();
      c++;
    end
    check("t3 wr_done latency", 64'(c), 64'd4);
    step();
    check("t3 ready after wr_done", {62'd0, a_bus.req_ready, a_bus.busy}, 64'd2);
    step();
    check("t3 held read accepted", {62'd0, a_bus.req_ready, a_bus.busy}, 64'd1);
    a_bus.req_valid = 1'b0;
    a_burst(first);
    check("t3 first beat latency", 64'(first), 64'd4);
    check_burst("t3", 32'h0000_0020, 32'h0000_0021, 32'hCAFE_0022, 32'h0000_0023);
    repeat (4) step();
    check("t3 one write", 64'(n_wr_a - w0), 64'd1);
    check("t3 one read", 64'(n_last_a - l0), 64'd1);

    // Reset during write wait
    a_write(10'h010, 32'h0000_0010);
    w0 = n_wr_a;
    a_issue(1'b1, 10'h010, 32'h1234_5678);
    step();
    reset_n = 1'b0;
    #1;
    check("t4 outs in reset", 64'(a_outs()), 64'({1'b1, 38'd0}));
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (8) step();
    check("t4 no wr_done", 64'(n_wr_a - w0), 64'd0);
    a_issue(1'b0, 10'h010, 32'h0);
    a_burst(first);
    check("t4 old word kept", {32'd0, cap_data[0]}, 64'h0000_0010);

    // Reset during beat 1
    l0 = n_last_a;
    a_issue(1'b0, 10'h004, 32'h0);
    c = 0;
    while (!a_bus.rd_valid && c < 20) begin
      step();
      c++;
    end
    step();
    check("t5 on beat1", {61'd0, a_bus.rd_valid, a_bus.rd_beat}, 64'd5);
    #2 reset_n = 1'b0;
    #1;
    check("t5 async drop", 64'({a_bus.rd_valid, a_bus.rd_last, a_bus.rd_beat, a_bus.rd_data}), 64'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (6) step();
    check("t5 ready after release", {61'd0, a_bus.req_ready, a_bus.busy, a_bus.rd_valid}, 64'd4);
    check("t5 no rd_last", 64'(n_last_a - l0), 64'd0);

    // Minimum latency, back-to-back write then read of same block
    b_bus.req_valid = 1'b1; b_bus.req_write = 1'b1;
    b_bus.req_addr = 10'h031; b_bus.req_wdata = 32'h5A5A_0031;
    step();
    b_bus.req_write = 1'b0; b_bus.req_addr = 10'h030;
    run_b(nb, da, fa, la);
    check("t6 wr busy cycles", 64'(nb), 64'd2);
    check("t6 wr_done cycle", 64'(da), 64'd1);
    step();
    b_bus.req_valid = 1'b0;
    check("t6 read accepted", {63'd0, b_bus.busy}, 64'd1);
    run_b(nb, da, fa, la);
    check("t6 rd busy cycles", 64'(nb), 64'd5);
    check("t6 first beat cycle", 64'(fa), 64'd1);
    check("t6 last beat cycle", 64'(la), 64'd4);
    check("t6 new data", {32'd0, capb[1]}, 64'h5A5A_0031);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
